// File: rtl/spi_pwm_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pwm_regbank
//  Purpose  : SPI-slave (mode 1, MSB first) register bank driving NUM_CH
//             PWM channels. SPI pins are oversampled on clk, so the whole
//             block lives in one clock domain.
//  Ports    : clk          system clock
//             rst_n        synchronous active-low reset
//             spi_sclk_i   SPI clock pin (asynchronous)
//             spi_cs_n_i   SPI chip select pin, active low (asynchronous)
//             spi_mosi_i   SPI master-out pin (asynchronous)
//             spi_miso_o   SPI slave-out data
//             pwm_out_o    PWM outputs, bit i = channel i
//             busy_o       high while a frame is in progress
//  Map      : 0x00 ID (RO), 0x01 CTRL, 0x02 PRESCALE, 0x03+i DUTY[i]
//  Revision : 1.0 - initial release
// ============================================================================
module spi_pwm_regbank #(
    parameter int          NUM_CH      = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  ID_VALUE    = 8'h96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic [NUM_CH-1:0] pwm_out_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, rise_q, fall_q, cs_q, mosi_q;
    logic                   armed_q;
    logic                   sclk_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];

    // The CS chain resets to "low" so that a CS that is held low through
    // reset is never mistaken for a fresh frame: armed_q only sets once CS
    // has actually been observed high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            cs_q        <= 1'b0;
            mosi_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_prev_q <= sclk_s;
            // Edge pulses are registered; CS and MOSI get one matching
            // delay stage so all three stay aligned.
            rise_q      <=  sclk_s & ~sclk_prev_q;
            fall_q      <= ~sclk_s &  sclk_prev_q;
            cs_q        <= cs_sync_q[SYNC_STAGES-1];
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
            if (cs_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] ctrl_q, ctrl_d;
    logic [7:0]        prescale_q, prescale_d;
    logic [7:0]        duty_q [NUM_CH];
    logic [7:0]        duty_d [NUM_CH];

    function automatic logic [7:0] read_reg(input logic [6:0] addr);
        logic [7:0] rdata;
        rdata = 8'h00;
        case (addr)
            7'h00:   rdata = ID_VALUE;
            7'h01:   rdata = 8'(ctrl_q);
            7'h02:   rdata = prescale_q;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (addr == 7'(3 + i)) begin
                        rdata = duty_q[i];
                    end
                end
            end
        endcase
        return rdata;
    endfunction

    // ------------------------------------------------------------------
    // SPI frame FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [6:0]  addr_q, addr_d;
    logic        miso_q, miso_d;
    logic        wr_en;
    logic [7:0]  rx_byte;

    assign rx_byte = {shift_q, mosi_q};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        miso_d    = miso_q;
        wr_en     = 1'b0;

        if (cs_q) begin
            // CS high ends any frame; a partial byte is simply dropped.
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                default: begin
                    if (fall_q) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ST_CMD: begin
                                    addr_d = rx_byte[6:0];
                                    if (rx_byte[7]) begin
                                        state_d = ST_READ;
                                        tx_d    = read_reg(rx_byte[6:0]);
                                    end else begin
                                        state_d = ST_WRITE;
                                    end
                                end
                                ST_WRITE: begin
                                    wr_en  = 1'b1;
                                    addr_d = addr_q + 7'd1;
                                end
                                default: begin
                                    addr_d = addr_q + 7'd1;
                                    tx_d   = read_reg(addr_q + 7'd1);
                                end
                            endcase
                        end
                    end
                    if (rise_q && state_q == ST_READ) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
            endcase
        end

        if (state_d != ST_READ) begin
            miso_d = 1'b0;
        end
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_d[i] = duty_q[i];
        end
        if (wr_en) begin
            if (addr_q == 7'h01) begin
                ctrl_d = rx_byte[NUM_CH-1:0];
            end
            if (addr_q == 7'h02) begin
                prescale_d = rx_byte;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr_q == 7'(3 + i)) begin
                    duty_d[i] = rx_byte;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM engine
    // ------------------------------------------------------------------
    logic [7:0]        presc_cnt_q, cnt_q;
    logic [7:0]        duty_act_q [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              tick;

    // >= keeps the prescaler from running to 255 if PRESCALE shrinks
    // below the current count.
    assign tick = (presc_cnt_q >= prescale_q);

    // Enable uses the next CTRL value so a disable lands on the same edge
    // that updates CTRL.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign pwm_d[gi] = ctrl_d[gi] && (cnt_q < duty_act_q[gi]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            tx_q        <= 8'd0;
            addr_q      <= 7'd0;
            miso_q      <= 1'b0;
            ctrl_q      <= '0;
            prescale_q  <= 8'd0;
            presc_cnt_q <= 8'd0;
            cnt_q       <= 8'd0;
            pwm_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]     <= 8'd0;
                duty_act_q[i] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            pwm_q       <= pwm_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= duty_d[i];
            end
            if (tick) begin
                presc_cnt_q <= 8'd0;
                cnt_q       <= cnt_q + 8'd1;
                // Duty takes effect only as the period restarts.
                if (cnt_q == 8'hFF) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        duty_act_q[i] <= duty_q[i];
                    end
                end
            end else begin
                presc_cnt_q <= presc_cnt_q + 8'd1;
            end
        end
    end

    assign spi_miso_o = miso_q;
    assign pwm_out_o  = pwm_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_pwm_regbank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_spi_pwm_regbank
//  Purpose  : Directed self-checking bench for spi_pwm_regbank: SPI single
//             and burst access, address wrap, aborted frames, PWM duty,
//             prescaler and glitch-free duty update.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_pwm_regbank;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       cs_n  = 1'b1;
    logic       mosi  = 1'b0;
    logic       miso;
    logic [3:0] pwm;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         n;
    int         t0;
    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];
    logic       busy_seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_pwm_regbank #(
        .NUM_CH      (4),
        .SYNC_STAGES (2),
        .ID_VALUE    (8'h96)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sclk_i (sclk),
        .spi_cs_n_i (cs_n),
        .spi_mosi_i (mosi),
        .spi_miso_o (miso),
        .pwm_out_o  (pwm),
        .busy_o     (busy)
    );

    task automatic wait_clk(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Mode 1 master: drive MOSI on SCLK rise, sample MISO at the end of
    // the low phase (just before the next rise).
    task automatic spi_frame(input int nbits, input int hp);
        cs_n = 1'b0;
        wait_clk(hp + 2);
        for (int b = 0; b < nbits; b++) begin
            sclk = 1'b1;
            mosi = tx_buf[b / 8][7 - (b % 8)];
            wait_clk(hp);
            sclk = 1'b0;
            wait_clk(hp);
            rx_buf[b / 8][7 - (b % 8)] = miso;
            if (b == 3) busy_seen = busy;
        end
        wait_clk(4);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(8);
    endtask

    // Count clocks until pwm[ch] equals v, giving up after bound.
    task automatic wait_level(input int ch, input logic v, input int bound, output int cnt);
        cnt = 0;
        while (pwm[ch] !== v && cnt < bound) begin
            cnt++;
            wait_clk(1);
        end
    endtask

    initial begin
        // Reset state
        wait_clk(5);
        check("reset_pwm",  32'(pwm),  32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_miso", 32'(miso), 32'h0);
        rst_n = 1'b1;
        wait_clk(5);

        // Reset while CS low: the frame is ignored until CS goes high
        cs_n = 1'b0;
        wait_clk(10);
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h0F;
        spi_frame(16, 4);
        tx_buf[0] = 8'h81; tx_buf[1] = 8'h00;
        spi_frame(16, 4);
        check("rst_midframe_ctrl", 32'(rx_buf[1]), 32'h00);

        // ID read
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h00;
        busy_seen = 1'b0;
        spi_frame(16, 4);
        check("id_read",      32'(rx_buf[1]), 32'h96);
        check("busy_in_frame", 32'(busy_seen), 32'h1);
        check("busy_after",    32'(busy),      32'h0);

        // Burst write DUTY0..3, burst read back
        tx_buf[0] = 8'h03; tx_buf[1] = 8'h40; tx_buf[2] = 8'h80;
        tx_buf[3] = 8'hC0; tx_buf[4] = 8'hFF;
        spi_frame(40, 4);
        tx_buf[0] = 8'h83; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        tx_buf[3] = 8'h00; tx_buf[4] = 8'h00;
        spi_frame(40, 4);
        check("burst_duty0", 32'(rx_buf[1]), 32'h40);
        check("burst_duty1", 32'(rx_buf[2]), 32'h80);
        check("burst_duty2", 32'(rx_buf[3]), 32'hC0);
        check("burst_duty3", 32'(rx_buf[4]), 32'hFF);

        // Aborted write to CTRL after 5 data bits
        tx_buf[0] = 8'h01; tx_buf[1] = 8'hFF;
        spi_frame(13, 4);
        tx_buf[0] = 8'h81; tx_buf[1] = 8'h00;
        spi_frame(16, 4);
        check("abort_ctrl", 32'(rx_buf[1]), 32'h00);
        // Following full frame; bits above NUM_CH read 0
        tx_buf[0] = 8'h01; tx_buf[1] = 8'hF5;
        spi_frame(16, 4);
        tx_buf[0] = 8'h81; tx_buf[1] = 8'h00;
        spi_frame(16, 4);
        check("ctrl_after_abort", 32'(rx_buf[1]), 32'h05);

        // Address wrap 0x7F -> 0x00
        tx_buf[0] = 8'hFF; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        spi_frame(24, 4);
        check("wrap_7f", 32'(rx_buf[1]), 32'h00);
        check("wrap_id", 32'(rx_buf[2]), 32'h96);
        // Write to ID ignored
        tx_buf[0] = 8'h00; tx_buf[1] = 8'h55;
        spi_frame(16, 4);
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h00;
        spi_frame(16, 4);
        check("id_write_ignored", 32'(rx_buf[1]), 32'h96);

        // PWM: CTRL=0x0F, PRESCALE=0, DUTY0=0x40
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h0F; tx_buf[2] = 8'h00; tx_buf[3] = 8'h40;
        spi_frame(32, 4);
        wait_level(0, 1'b0, 600, n);
        wait_level(0, 1'b1, 600, n);
        check("pwm0_rise_seen", 32'(n < 600), 32'h1);
        wait_level(0, 1'b0, 600, n);
        check("pwm0_high_64", 32'(n), 32'd64);
        wait_level(0, 1'b1, 600, n);
        check("pwm0_low_192", 32'(n), 32'd192);

        // DUTY0 -> 0x80 mid-period: no change until the next wrap
        t0 = cyc;
        tx_buf[0] = 8'h03; tx_buf[1] = 8'h80;
        spi_frame(16, 2);
        check("pwm0_no_glitch", 32'(pwm[0]), 32'h0);
        wait_level(0, 1'b1, 600, n);
        check("pwm0_period_256", 32'(cyc - t0), 32'd256);
        wait_level(0, 1'b0, 600, n);
        check("pwm0_high_128", 32'(n), 32'd128);

        // PRESCALE=3, DUTY1=0x80
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h03; tx_buf[2] = 8'h40; tx_buf[3] = 8'h80;
        spi_frame(32, 4);
        wait_level(1, 1'b0, 3000, n);
        wait_level(1, 1'b1, 3000, n);
        check("pwm1_rise_seen", 32'(n < 3000), 32'h1);
        wait_level(1, 1'b0, 3000, n);
        check("pwm1_high_512", 32'(n), 32'd512);
        wait_level(1, 1'b1, 3000, n);
        check("pwm1_low_512", 32'(n), 32'd512);

        // Clear CTRL bit1 while channel 1 is high
        check("pwm1_high_before", 32'(pwm[1]), 32'h1);
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h0D;
        spi_frame(16, 2);
        check("pwm1_disabled", 32'(pwm[1]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
